alu_nbit_seq: RTL and testbench
===============================

Name: alu_nbit_seq

Overview:
Parametrised, handshaked successor to the 32-bit MIPS ALU. Word width is generic. The op field widens to 4 bits and adds unsigned DIV next to MOD. Single-cycle logic/arith ops complete with 1-cycle latency; MOD/DIV run an iterative restoring divider for WIDTH cycles. Sits between the register-read stage and writeback, with valid/ready on both sides so the pipeline can stall on long ops.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
CLK  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
in_valid  input  1  operands/op presented
in_ready  output  1  block can accept an op
a  input  WIDTH  operand A
b  input  WIDTH  operand B
alu_op  input  4  operation select
c_in  input  1  carry-in for ADD; borrow-in for SUB
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  result word
c_out  output  1  carry out (ADD/SUB); see MUL
zero  output  1  result == 0
ovf  output  1  signed overflow (ADD/SUB only, else 0)
div_zero  output  1  MOD/DIV with b == 0
op_err  output  1  unsupported opcode

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOR
  - 0100 SLT: signed, result = {0..., a<b}
  - 0101 ADD: {c_out,result} = a+b+c_in
  - 0110 SUB: {c_out,result} = a+~b+!c_in; c_out=1 means no borrow
  - 0111 MOD: unsigned a%b; 1000 DIV: unsigned a/b
  - 1001 MUL: optional; see below
  - All others illegal.
- FSM states IDLE, CALC, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Accept: in_valid && in_ready at a rising edge. a, b, alu_op and c_in are registered at accept. Input changes after accept have no effect.
- Single-cycle ops, illegal ops, and MOD/DIV with b==0: IDLE->DONE. out_valid is high the cycle after accept (latency 1).
- MOD/DIV with b!=0: IDLE->CALC. One quotient bit per cycle, MSB first, counter WIDTH-1 down to 0. CALC->DONE after the WIDTH-th iteration. out_valid rises exactly WIDTH+1 cycles after accept.
- DONE: result and all flags held stable while out_ready=0. On out_ready=1, DONE->IDLE; in_ready returns the next cycle. There is no accept in the same cycle as result handoff (max throughput 1 op / 2 cycles).
- Division by zero: DIV result = all ones, MOD result = a, div_zero=1, c_out=0.
- Illegal op: result 0, op_err=1, zero=1, other flags 0.
- zero is computed from the final result for every op. ovf is valid for ADD/SUB only. c_out is 0 for logic ops, SLT, MOD and DIV.
- Reset (async, reset=0):
  - State goes to IDLE; counter and divider registers clear.
  - Outputs: result=0, all flags 0, out_valid=0, in_ready=1 (held while in reset).
  - Reset during CALC or DONE abandons the op; no partial result is emitted.
  - First accept is possible on the first rising edge after reset deasserts.

Optional Feature:
ALU_MUL_EN
- Defined: opcode 1001 = unsigned shift-add multiply, WIDTH iterations in CALC, same latency as DIV (WIDTH+1). result = low WIDTH bits of the product; c_out = OR of the high WIDTH bits (product truncated); zero from result.
- Undefined: 1001 is illegal (op_err=1, latency 1) and no multiplier datapath is built.

Test Plan:
1. WIDTH=32, a=0x0000F0F0, b=0x00000FF0, ops 0000..0011 -> results 0x000000F0, 0x0000FFF0, 0x0000FF00, 0xFFFF000F; each out_valid 1 cycle after accept.
2. ADD 15+12 c_in=0 -> 27, c_out=0. SUB 15-12 -> 3, c_out=1. ADD 0xFFFFFFFF+1 -> 0, c_out=1, zero=1. ADD 0x7FFFFFFF+1 -> 0x80000000, ovf=1.
3. SLT a=0xFFFFFFFF, b=1 -> result 1. SLT a=15, b=12 -> 0, zero=1.
4. MOD 15,6 -> 3; DIV 15,6 -> 2. out_valid asserts exactly 33 cycles after accept. Change a/b during CALC -> result unaffected. With WIDTH=8, MOD 200,7 -> 4 in 9 cycles.
5. DIV a=7, b=0 -> 0xFFFFFFFF, div_zero=1, latency 1. Hold out_ready=0 for 5 cycles -> result/flags stable, in_ready=0. Illegal op 1111 -> op_err=1.
6. Assert reset 10 cycles into a MOD -> out_valid=0, result=0, in_ready=1 immediately. After release, ADD 2+3 -> 5 with latency 1. With ALU_MUL_EN: MUL 0x10000 x 0x10000 -> result 0, c_out=1.

Source files
------------

// File: rtl/alu_nbit_seq.sv
// Handshaked N-bit ALU: 1-cycle logic/arith ops plus an iterative restoring divider for MOD/DIV.
// Optional feature macro ALU_MUL_EN adds a shift-add multiplier on opcode 1001.
module alu_nbit_seq #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             zero,
    output logic             ovf,
    output logic             div_zero,
    output logic             op_err,
    output logic [1:0]       state_dbg
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int MSB   = WIDTH - 1;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_SLT = 4'd4;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_MOD = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd9;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
    state_t state, state_n;

    logic             accept, is_long, last;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] b_q, rem_q, quo_q, rem_n, quo_n;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   sum, rem_sh, trial;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_ovf, sc_dz, sc_err;
    logic [WIDTH-1:0] long_res;
    logic             long_c;
`ifdef ALU_MUL_EN
    logic [WIDTH:0]   msum;
`endif
    logic [WIDTH-1:0] res_q;
    logic             c_q, z_q, o_q, dz_q, err_q;

    assign accept = in_valid && in_ready;
    assign last   = (cnt_q == '0);

    always_comb begin
        is_long = ((alu_op == OP_MOD) || (alu_op == OP_DIV)) && (b != '0);
`ifdef ALU_MUL_EN
        if (alu_op == OP_MUL) is_long = 1'b1;
`endif
    end

    // Single-cycle results straight from the operands being accepted.
    always_comb begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_ovf = 1'b0;
        sc_dz  = 1'b0;
        sc_err = 1'b0;
        sum    = '0;
        case (alu_op)
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_NOR: sc_res = ~(a | b);
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_ADD: begin
                sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ~c_in};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
                sc_ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_MOD: begin
                sc_res = a;
                sc_dz  = 1'b1;
            end
            OP_DIV: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
`ifdef ALU_MUL_EN
            OP_MUL: sc_res = '0;
`endif
            default: sc_err = 1'b1;
        endcase
    end

    // One iteration: quo_q shifts dividend bits out MSB-first while quotient bits shift in.
    always_comb begin
        rem_sh = {rem_q, quo_q[MSB]};
        trial  = rem_sh - {1'b0, b_q};
        rem_n  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_n  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
`ifdef ALU_MUL_EN
        msum = {1'b0, rem_q} + (quo_q[0] ? {1'b0, b_q} : '0);
        if (op_q == OP_MUL) begin
            rem_n = msum[WIDTH:1];
            quo_n = {msum[0], quo_q[WIDTH-1:1]};
        end
`endif
        long_res = (op_q == OP_MOD) ? rem_n : quo_n;
        long_c   = 1'b0;
`ifdef ALU_MUL_EN
        long_c = (op_q == OP_MUL) && (rem_n != '0);
`endif
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = is_long ? CALC : DONE;
            CALC: if (last) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        state_dbg = state;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            op_q  <= '0;
            b_q   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            res_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            o_q   <= 1'b0;
            dz_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (accept) begin
            op_q  <= alu_op;
            b_q   <= b;
            quo_q <= a;
            rem_q <= '0;
            cnt_q <= CNT_W'(WIDTH - 1);
            if (!is_long) begin
                res_q <= sc_res;
                c_q   <= sc_c;
                z_q   <= (sc_res == '0);
                o_q   <= sc_ovf;
                dz_q  <= sc_dz;
                err_q <= sc_err;
            end
        end else if (state == CALC) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last) begin
                res_q <= long_res;
                c_q   <= long_c;
                z_q   <= (long_res == '0);
                o_q   <= 1'b0;
                dz_q  <= 1'b0;
                err_q <= 1'b0;
            end
        end
    end

    assign result   = res_q;
    assign c_out    = c_q;
    assign zero     = z_q;
    assign ovf      = o_q;
    assign div_zero = dz_q;
    assign op_err   = err_q;
endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq: a 32-bit instance with random and directed ops,
// plus an 8-bit instance for the short divider latency.
module tb_alu_nbit_seq;
    localparam int W  = 32;
    localparam int EW = 8 + 5 + W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, out_ready, c_in;
    logic [W-1:0]  a, b, result;
    logic [3:0]    alu_op;
    logic          c_out, zero, ovf, div_zero, op_err;
    logic [1:0]    state_dbg;

    logic          in_valid8, in_ready8, out_valid8, c_in8;
    logic [7:0]    a8, b8, result8;
    logic [3:0]    alu_op8;
    logic          c_out8, zero8, ovf8, div_zero8, op_err8;
    logic [1:0]    state_dbg8;
    logic          out_ready8 = 1'b1;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .CLK(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_op(alu_op), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .c_out(c_out), .zero(zero), .ovf(ovf), .div_zero(div_zero),
        .op_err(op_err), .state_dbg(state_dbg)
    );

    alu_nbit_seq #(.WIDTH(8)) dut8 (
        .CLK(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .alu_op(alu_op8), .c_in(c_in8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .c_out(c_out8), .zero(zero8), .ovf(ovf8), .div_zero(div_zero8),
        .op_err(op_err8), .state_dbg(state_dbg8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int hold_n   = 0;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    logic [15:0]   exp8_q[$];
    int            acc8_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: {latency, op_err, div_zero, ovf, zero, c_out, result}.
    function automatic logic [EW-1:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                            input logic [W-1:0] y, input logic c);
        logic [W-1:0]    r;
        logic            co, o, dz, er;
        int              lat;
        longint unsigned u;
        longint          s;
        r = '0; co = 0; o = 0; dz = 0; er = 0; lat = 1;
        case (op)
            4'd0: r = x & y;
            4'd1: r = x | y;
            4'd2: r = x ^ y;
            4'd3: r = ~(x | y);
            4'd4: r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'd5: begin
                u  = 64'(x) + 64'(y) + 64'(c);
                r  = u[31:0];
                co = (u >= 64'h1_0000_0000);
                s  = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
                o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd6: begin
                r  = x - y - W'(c);
                co = (64'(x) >= 64'(y) + 64'(c));
                s  = longint'($signed(x)) - longint'($signed(y)) - longint'(c);
                o  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7: if (y == 0) begin r = x; dz = 1; end else begin r = x % y; lat = W + 1; end
            4'd8: if (y == 0) begin r = '1; dz = 1; end else begin r = x / y; lat = W + 1; end
`ifdef ALU_MUL_EN
            4'd9: begin
                u   = 64'(x) * 64'(y);
                r   = u[31:0];
                co  = (u[63:32] != 0);
                lat = W + 1;
            end
`endif
            default: er = 1;
        endcase
        return {8'(lat), er, dz, o, (r == 0), co, r};
    endfunction

    task automatic send_now(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c);
        int guard = 0;
        in_valid = 1; alu_op = op; a = x; b = y; c_in = c;
        while (!in_ready && guard < 300) begin @(negedge clk); guard++; end
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 0;
            return;
        end
        exp_q.push_back(model(op, x, y, c));
        @(posedge clk); #1;
        acc_q.push_back(cyc);
        in_valid = 0; a = $urandom; b = $urandom; alu_op = 4'($urandom_range(0, 15)); c_in = 1'($urandom);
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
        @(negedge clk);
        send_now(op, x, y, c);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && g < 3000) begin @(negedge clk); g++; end
        if (exp_q.size() != 0 || exp8_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size() + exp8_q.size()), 64'd0);
            exp_q.delete(); acc_q.delete(); exp8_q.delete(); acc8_q.delete();
        end
    endtask

    task automatic send8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        int guard = 0;
        logic [7:0] r;
        int lat;
        @(negedge clk);
        in_valid8 = 1; alu_op8 = op; a8 = x; b8 = y; c_in8 = 0;
        while (!in_ready8 && guard < 300) begin @(negedge clk); guard++; end
        if (!in_ready8) begin
            check("in_ready8_timeout", 64'(in_ready8), 64'd1);
            in_valid8 = 0;
            return;
        end
        lat = (y == 0) ? 1 : 9;
        if (op == 4'd7) r = (y == 0) ? x : x % y;
        else            r = (y == 0) ? 8'hFF : x / y;
        exp8_q.push_back({8'(lat), r});
        @(posedge clk); #1;
        acc8_q.push_back(cyc);
        in_valid8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
    endtask

    // Monitor for the 32-bit instance; also decides out_ready (random or held).
    initial begin
        logic [EW-1:0] e;
        bit first = 1;
        out_ready = 0;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                    out_ready = 1;
                end else begin
                    e = exp_q[0];
                    if (first) check("latency", 64'(cyc - acc_q[0] + 1), 64'(e[EW-1:W+5]));
                    first = 0;
                    check("outputs", {27'd0, op_err, div_zero, ovf, zero, c_out, result}, 64'(e[W+4:0]));
                    check("in_ready_low_in_done", 64'(in_ready), 64'd0);
                    if (hold_n > 0) begin out_ready = 0; hold_n--; end
                    else out_ready = ($urandom_range(0, 3) != 0);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        first = 1;
                    end
                end
            end else begin
                out_ready = 0;
            end
        end
    end

    initial begin
        logic [15:0] e8;
        forever begin
            @(negedge clk);
            if (out_valid8) begin
                if (exp8_q.size() == 0 || acc8_q.size() == 0) begin
                    check("unexpected_out_valid8", 64'(out_valid8), 64'd0);
                end else begin
                    e8 = exp8_q.pop_front();
                    check("latency8", 64'(cyc - acc8_q.pop_front() + 1), 64'(e8[15:8]));
                    check("result8", 64'(result8), 64'(e8[7:0]));
                end
            end
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [3:0]   op;
        logic [W-1:0] x, y;
        reset = 0; in_valid = 0; a = 0; b = 0; alu_op = 0; c_in = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; alu_op8 = 0; c_in8 = 0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_outputs", {58'd0, op_err, div_zero, ovf, zero, c_out, (result != 0)}, 64'd0);
        reset = 1;

        // Logic ops, arithmetic, SLT
        send(4'd0, 32'h0000F0F0, 32'h00000FF0, 0);
        send(4'd1, 32'h0000F0F0, 32'h00000FF0, 0);
        send(4'd2, 32'h0000F0F0, 32'h00000FF0, 0);
        send(4'd3, 32'h0000F0F0, 32'h00000FF0, 0);
        send(4'd5, 32'd15, 32'd12, 0);
        send(4'd6, 32'd15, 32'd12, 0);
        send(4'd5, 32'hFFFF_FFFF, 32'd1, 0);
        send(4'd5, 32'h7FFF_FFFF, 32'd1, 0);
        send(4'd6, 32'd3, 32'd5, 1);
        send(4'd4, 32'hFFFF_FFFF, 32'd1, 0);
        send(4'd4, 32'd15, 32'd12, 0);
        // Divider; operands are scrambled by send_now during CALC
        send(4'd7, 32'd15, 32'd6, 0);
        send(4'd8, 32'd15, 32'd6, 0);
        send(4'd8, 32'hFFFF_FFFF, 32'd1, 0);
        drain();
        hold_n = 5;
        send(4'd8, 32'd7, 32'd0, 0);
        send(4'd7, 32'd7, 32'd0, 0);
        send(4'd15, 32'd1, 32'd2, 0);
        send(4'd9, 32'h0001_0000, 32'h0001_0000, 0);
        send(4'd9, 32'd6, 32'd7, 0);

        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            x  = pick();
            y  = pick();
            send(op, x, y, 1'($urandom));
        end
        drain();

        // Reset in the middle of a divide
        send(4'd7, 32'd1000, 32'd7, 0);
        repeat (9) @(negedge clk);
        reset = 0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_result", 64'(result), 64'd0);
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete(); acc_q.delete();
        repeat (2) @(negedge clk);
        check("rst_mid_held_valid", 64'(out_valid), 64'd0);
        reset = 1;
        send_now(4'd5, 32'd2, 32'd3, 0);
        drain();

        // 8-bit instance
        send8(4'd7, 8'd200, 8'd7);
        send8(4'd8, 8'd200, 8'd7);
        send8(4'd8, 8'd9, 8'd0);
        for (int i = 0; i < 12; i++) send8(4'($urandom_range(7, 8)), 8'($urandom), 8'($urandom_range(1, 255)));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
